// File: rtl/cnt_rmw_pkg.sv
// Shared encodings and constants for the counter read-modify-write engine.
package cnt_rmw_pkg;

  typedef enum logic [1:0] {
    OP_READ = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned RMW_LAT = 2;

endpackage

// File: rtl/cnt_rmw_engine_if.sv
// Request/response bundle between a counter client (master) and the engine (slave).
interface cnt_rmw_engine_if
  import cnt_rmw_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = 8
);

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  op_e                   req_op;
  logic                  rsp_valid;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic [CNT_WIDTH-1:0]  rsp_cnt;
  logic                  rsp_flag;

  modport master (
    output req_valid, req_addr, req_op,
    input  req_ready, rsp_valid, rsp_addr, rsp_cnt, rsp_flag
  );

  modport slave (
    input  req_valid, req_addr, req_op,
    output req_ready, rsp_valid, rsp_addr, rsp_cnt, rsp_flag
  );

endinterface

// File: rtl/cnt_rmw_alu.sv
// Combinational counter update: old value and op in, new value and flag out.
// CNT_RMW_SAT_EN selects saturating arithmetic; otherwise counters wrap.
module cnt_rmw_alu
  import cnt_rmw_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic [CNT_WIDTH-1:0] old_i,
  input  op_e                  op_i,
  output logic [CNT_WIDTH-1:0] new_o,
  output logic                 flag_o
);

  localparam logic [CNT_WIDTH-1:0] CntMax = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  always_comb begin
    new_o  = old_i;
    flag_o = 1'b0;
    unique case (op_i)
      OP_READ: ;
      OP_INC: begin
`ifdef CNT_RMW_SAT_EN
        if (old_i == CntMax) flag_o = 1'b1;
        else                 new_o  = old_i + CntOne;
`else
        new_o  = old_i + CntOne;
        flag_o = (old_i == CntMax);
`endif
      end
      OP_DEC: begin
`ifdef CNT_RMW_SAT_EN
        if (old_i == '0) flag_o = 1'b1;
        else             new_o  = old_i - CntOne;
`else
        new_o  = old_i - CntOne;
        flag_o = (old_i == '0);
`endif
      end
      OP_CLR:  new_o = '0;
      default: ;
    endcase
  end

endmodule

// File: rtl/cnt_rmw_engine.sv
// Pipelined read-modify-write engine over an external write-first SDP counter RAM.
// Saturating vs wrapping arithmetic is chosen by CNT_RMW_SAT_EN (see cnt_rmw_alu).
module cnt_rmw_engine
  import cnt_rmw_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cnt_rmw_engine_if.slave       bus,
  output logic                  init_done_o,
  output logic                  ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_a_o,
  output logic [CNT_WIDTH-1:0]  ram_data_a_o,
  output logic                  ram_re_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_b_o,
  input  logic [CNT_WIDTH-1:0]  ram_data_b_i
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] AddrOne  = ADDR_WIDTH'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  init_done_q, init_done_d;

  logic                  s1_valid_q;
  logic [ADDR_WIDTH-1:0] s1_addr_q;
  op_e                   s1_op_q;

  logic                  rsp_valid_q;
  logic [ADDR_WIDTH-1:0] rsp_addr_q;
  logic [CNT_WIDTH-1:0]  rsp_cnt_q;
  logic                  rsp_flag_q;

  logic                  req_ready;
  logic                  accept;
  logic                  s1_wr;
  logic [CNT_WIDTH-1:0]  alu_new;
  logic                  alu_flag;

  cnt_rmw_alu #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_alu (
    .old_i  (ram_data_b_i),
    .op_i   (s1_op_q),
    .new_o  (alu_new),
    .flag_o (alu_flag)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    init_done_d  = init_done_q;
    req_ready    = 1'b0;
    accept       = 1'b0;
    ram_wr_en_o  = 1'b0;
    ram_addr_a_o = '0;
    ram_data_a_o = '0;
    ram_re_en_o  = 1'b0;
    ram_addr_b_o = '0;
    s1_wr        = s1_valid_q && (s1_op_q != OP_READ);
    unique case (state_q)
      ST_INIT: begin
        // Gated by rst_n so the RAM sees no write strobe while reset is held.
        ram_wr_en_o  = rst_n;
        ram_addr_a_o = ptr_q;
        ptr_d        = ptr_q + AddrOne;
        if (ptr_q == LastAddr) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        req_ready    = 1'b1;
        accept       = bus.req_valid;
        ram_re_en_o  = accept;
        ram_addr_b_o = accept ? bus.req_addr : '0;
        // Same-address back-to-back hazards are resolved by the RAM's write-first bypass.
        ram_wr_en_o  = s1_wr;
        ram_addr_a_o = s1_wr ? s1_addr_q : '0;
        ram_data_a_o = s1_wr ? alu_new : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      ptr_q       <= '0;
      init_done_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_op_q     <= OP_READ;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_cnt_q   <= '0;
      rsp_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      init_done_q <= init_done_d;
      s1_valid_q  <= accept;
      if (accept) begin
        s1_addr_q <= bus.req_addr;
        s1_op_q   <= bus.req_op;
      end
      rsp_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        rsp_addr_q <= s1_addr_q;
        rsp_cnt_q  <= alu_new;
        rsp_flag_q <= alu_flag;
      end
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.rsp_cnt   = rsp_cnt_q;
  assign bus.rsp_flag  = rsp_flag_q;
  assign init_done_o   = init_done_q;

endmodule

// File: tb/tb_cnt_rmw_engine.sv
// Scoreboard bench for cnt_rmw_engine with a behavioural write-first SDP RAM beside it.
module tb_cnt_rmw_engine;
  import cnt_rmw_pkg::*;

  localparam int unsigned AW = 4;
  localparam int unsigned CW = 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [CW-1:0] cnt;
    logic          flag;
    int unsigned   due;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          init_done;
  logic          ram_wr_en;
  logic [AW-1:0] ram_addr_a;
  logic [CW-1:0] ram_data_a;
  logic          ram_re_en;
  logic [AW-1:0] ram_addr_b;
  logic [CW-1:0] ram_data_b;
  logic [CW-1:0] mem [2**AW];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;
  exp_t        sb_q[$];

  cnt_rmw_engine_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  cnt_rmw_engine #(
    .ADDR_WIDTH (AW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .init_done_o  (init_done),
    .ram_wr_en_o  (ram_wr_en),
    .ram_addr_a_o (ram_addr_a),
    .ram_data_a_o (ram_data_a),
    .ram_re_en_o  (ram_re_en),
    .ram_addr_b_o (ram_addr_b),
    .ram_data_b_i (ram_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_addr_a] <= ram_data_a;
    if (ram_re_en)
      ram_data_b <= (ram_wr_en && ram_addr_a == ram_addr_b) ? ram_data_a : mem[ram_addr_b];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response must match the head of the scoreboard on its due cycle.
  always @(negedge clk) begin
    if (bus.rsp_valid) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL rsp_unexpected: got addr=%0d cnt=%0d flag=%0b expected none",
                 bus.rsp_addr, bus.rsp_cnt, bus.rsp_flag);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (bus.rsp_addr !== e.addr || bus.rsp_cnt !== e.cnt || bus.rsp_flag !== e.flag
            || cyc != e.due) begin
          n_err++;
          $display("FAIL rsp: got addr=%0d cnt=%0d flag=%0b cyc=%0d expected addr=%0d cnt=%0d flag=%0b cyc=%0d",
                   bus.rsp_addr, bus.rsp_cnt, bus.rsp_flag, cyc, e.addr, e.cnt, e.flag, e.due);
        end
      end
    end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      exp_t e;
      e = sb_q.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL rsp_missing: got no rsp_valid expected addr=%0d cnt=%0d at cyc=%0d",
               e.addr, e.cnt, e.due);
    end
  end

  task automatic issue(input logic [AW-1:0] a, input op_e op, input logic [CW-1:0] c,
                       input logic f, input bit track);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_op    = op;
    if (track) sb_q.push_back('{addr: a, cnt: c, flag: f, due: cyc + RMW_LAT});
  endtask

  task automatic idle();
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_op    = OP_READ;
  endtask

  initial begin
    int w;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_op    = OP_READ;
    repeat (3) @(negedge clk);
    check("rst_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_init_done", init_done, 0);
    check("rst_ram_outs", {ram_wr_en, ram_re_en, ram_addr_a, ram_data_a, ram_addr_b}, 0);
    check("rst_rsp_data", {bus.rsp_addr, bus.rsp_cnt, bus.rsp_flag}, 0);

    // Initialisation sweep: one zero write per cycle, addresses 0..15.
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      check("init_sweep", {ram_wr_en, bus.req_ready, ram_addr_a, ram_data_a},
            {1'b1, 1'b0, i[3:0], 8'h00});
      @(negedge clk);
      #1;
    end
    check("init_done", {init_done, bus.req_ready, ram_wr_en}, 3'b110);

    // Back-to-back INC on one address relies on the RAM bypass.
    for (int k = 1; k <= 5; k++) issue(4'd3, OP_INC, 8'(k), 1'b0, 1'b1);
    issue(4'd1, OP_INC, 8'd1, 1'b0, 1'b1);
    issue(4'd2, OP_INC, 8'd1, 1'b0, 1'b1);
    issue(4'd1, OP_READ, 8'd1, 1'b0, 1'b1);
    issue(4'd2, OP_READ, 8'd1, 1'b0, 1'b1);
    idle();
    issue(4'd3, OP_DEC, 8'd4, 1'b0, 1'b1);
    idle();

    for (int k = 1; k <= 255; k++) issue(4'd0, OP_INC, 8'(k), 1'b0, 1'b1);
`ifdef CNT_RMW_SAT_EN
    issue(4'd0, OP_INC, 8'd255, 1'b1, 1'b1);
    issue(4'd4, OP_DEC, 8'd0, 1'b1, 1'b1);
    issue(4'd0, OP_READ, 8'd255, 1'b0, 1'b1);
    issue(4'd4, OP_READ, 8'd0, 1'b0, 1'b1);
`else
    issue(4'd0, OP_INC, 8'd0, 1'b1, 1'b1);
    issue(4'd4, OP_DEC, 8'd255, 1'b1, 1'b1);
    issue(4'd0, OP_READ, 8'd0, 1'b0, 1'b1);
    issue(4'd4, OP_READ, 8'd255, 1'b0, 1'b1);
`endif
    idle();

    for (int k = 1; k <= 7; k++) issue(4'd5, OP_INC, 8'(k), 1'b0, 1'b1);
    issue(4'd5, OP_CLR, 8'd0, 1'b0, 1'b1);
    issue(4'd5, OP_READ, 8'd0, 1'b0, 1'b1);
    idle();
    repeat (4) @(negedge clk);

    // Reset mid-stream: first three responses land, the rest are dropped.
    for (int k = 1; k <= 3; k++) issue(4'd6, OP_INC, 8'(k), 1'b0, 1'b1);
    issue(4'd6, OP_INC, 8'd0, 1'b0, 1'b0);
    issue(4'd6, OP_INC, 8'd0, 1'b0, 1'b0);
    #2;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    check("midrst_state", {init_done, bus.req_ready, bus.rsp_valid, ram_wr_en}, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_rsp", bus.rsp_valid, 0);
    end
    rst_n = 1'b1;
    w = 0;
    while (!init_done && w < 40) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("reinit_len", w, 16);

    for (int a = 0; a < 16; a++) issue(4'(a), OP_READ, 8'd0, 1'b0, 1'b1);
    idle();

    w = 0;
    while (sb_q.size() != 0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("drain", sb_q.size(), 0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
